// File: rtl/hv_classifier.sv
// hv_classifier: associative-memory stage of the HDC seizure-detection datapath.
// Accumulates the Hamming distance from a serially delivered query hypervector
// to two class prototypes (0 = interictal, 1 = ictal). After DIM accepted bits
// it registers a class decision and pulses done for one cycle.
module hv_classifier #(
  parameter int DIM   = 10000,
  parameter int IDX_W = $clog2(DIM),
  parameter int DST_W = $clog2(DIM + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             in_bit,
  input  logic             proto_0_bit,
  input  logic             proto_1_bit,
  output logic [IDX_W-1:0] bit_idx,
  output logic             ready,
  output logic [DST_W-1:0] dist_0,
  output logic [DST_W-1:0] dist_1,
  output logic             class_out,
  output logic             done
);

  localparam logic [1:0] ST_ACC  = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

  logic [1:0]       state;
  logic             first_bit;
  logic             last_bit;
  logic             mis_0;
  logic             mis_1;
  logic [DST_W-1:0] next_0;
  logic [DST_W-1:0] next_1;

  // Per-bit mismatch and next distance. Index 0 restarts from zero, so the
  // previous vector's distances stay visible until the next vector really starts.
  assign first_bit = (bit_idx == '0);
  assign last_bit  = (bit_idx == LAST_IDX);
  assign mis_0     = in_bit ^ proto_0_bit;
  assign mis_1     = in_bit ^ proto_1_bit;
  assign next_0    = (first_bit ? '0 : dist_0) + {{(DST_W-1){1'b0}}, mis_0};
  assign next_1    = (first_bit ? '0 : dist_1) + {{(DST_W-1){1'b0}}, mis_1};

  // Status outputs decoded straight from the state register (glitch-free).
  assign ready = (state == ST_ACC);
  assign done  = (state == ST_DONE);

  // FSM, bit index, distance accumulators and class decision.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; mixing in = would make results order-dependent.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= ST_ACC;
      bit_idx   <= '0;
      dist_0    <= '0;
      dist_1    <= '0;
      class_out <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (en) begin
            dist_0 <= next_0;
            dist_1 <= next_1;
            if (last_bit) begin
              bit_idx <= '0;
              state   <= ST_CMP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        ST_CMP: begin
          // Strict compare: a tie keeps the conservative interictal class.
          class_out <= (dist_1 < dist_0);
          state     <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_ACC;
        end
        default: begin
          state <= ST_ACC;
        end
      endcase
    end
  end

endmodule

// File: doc/hv_classifier.md
# hv_classifier

Associative-memory stage of the HDC seizure-detection datapath. It sits directly downstream of `bundler_bit` and consumes the bundled query hypervector one bit per `en` strobe, with `en` driven by the bundler's `done` and `in_bit` by its `out_bit`. It accumulates the Hamming distance to two class prototypes: class 0 is interictal and class 1 is ictal. After `DIM` bits it issues a registered class decision with a one-cycle `done` pulse.

## Interface
- `DIM`, 10000: hypervector dimension in bits, ≥ 2.
- `IDX_W`, `$clog2(DIM)`: width of the bit index.
- `DST_W`, `$clog2(DIM+1)`: width of each distance.

- `clk` in 1: single clock; all state updates on the rising edge.
- `nrst` in 1: asynchronous, active-low reset.
- `en` in 1: one-cycle strobe; `in_bit`, `proto_0_bit` and `proto_1_bit` are valid in this cycle.
- `in_bit` in 1: query hypervector bit at index `bit_idx`.
- `proto_0_bit` in 1: class-0 prototype bit at `bit_idx`, from external memory with combinational read.
- `proto_1_bit` in 1: class-1 prototype bit at `bit_idx`.
- `bit_idx` out `IDX_W`: index of the next bit to accept; drives the prototype memory address.
- `ready` out 1: high when `en` will be accepted (state ACC).
- `dist_0` out `DST_W`: Hamming distance of query to prototype 0.
- `dist_1` out `DST_W`: Hamming distance of query to prototype 1.
- `class_out` out 1: decided class.
- `done` out 1: one-cycle pulse; `class_out`, `dist_0` and `dist_1` are final.

## Operation
- FSM states: ACC, CMP, DONE. Reset state is ACC.
- **ACC**
  - `en`=1 accepts a bit.
  - `mis0 = in_bit ^ proto_0_bit`; `mis1 = in_bit ^ proto_1_bit`.
  - If `bit_idx`==0, base distances are 0; otherwise base is the current `dist_0`/`dist_1`.
  - `dist_k <= base_k + mis_k`.
  - If `bit_idx`==`DIM`-1: `bit_idx <= 0`, go to CMP. Otherwise `bit_idx <= bit_idx + 1`.
  - `en`=0: all state held, so arbitrary gaps between strobes are allowed.
- **CMP**
  - `class_out <= (dist_1 < dist_0)`.
  - Ties resolve to class 0 (the conservative choice).
  - Go to DONE.
- **DONE**
  - `done`=1 for exactly this cycle.
  - Next state ACC.
- `en` in CMP or DONE is ignored: no counter, distance or state change, and no error flag. Upstream spacing (≥ 2 idle cycles between bundler results) guarantees this never drops data in-system.
- Distances and `class_out` hold their last values until the first bit of the next vector is accepted. `class_out` holds until the next CMP.
- Width rule: a distance is at most `DIM`, which `DST_W` represents exactly, so there is no saturation logic.
- `ready = (state == ACC)`, decoded combinationally from the state register.
- `nrst`=0 at any time, including mid-vector, immediately clears state, index, distances, `class_out` and `done`. The partial vector is discarded.

## Timing
- Reset values:
  - `bit_idx`=0, `dist_0`=0, `dist_1`=0, `class_out`=0, `done`=0.
  - `ready`=1 (state ACC).
- Accept: distances and `bit_idx` update on the edge that samples `en`=1.
- Latency from the edge accepting bit `DIM`-1:
  - CMP occupies cycle +1.
  - `class_out` is updated at the end of cycle +1.
  - `done` is high in cycle +2, with `class_out` already valid.
- Throughput: `DIM` accepted strobes + 2 cycles per classification.
- `ready` is low in CMP and DONE and high again the cycle after `done`.

## Test plan
- **Reset:** `nrst`=0 with random inputs → all outputs at reset values, `ready`=1. Release, idle 5 cycles → no change.
- **Clear class 1 (`DIM`=8):**
  - Stimulus: `in_bit`=1 for all bits, `proto_0`=0, `proto_1`=1, `en` every cycle.
  - Required: `dist_0`=8, `dist_1`=0, `class_out`=1.
  - `done` is high exactly 2 cycles after the 8th accept edge, for 1 cycle.
- **Tie (`DIM`=8):**
  - Stimulus: `in_bit`=0 for all bits, `proto_0`=11000000, `proto_1`=00000011.
  - Required: `dist_0`=2, `dist_1`=2, `class_out`=0.
- **Gapped strobes:**
  - Stimulus: `en` pulsed once per 10 cycles, as from `bundler_bit`. Extra `en` pulses in the CMP and DONE cycles.
  - Required: `bit_idx` holds between pulses, and the extra pulses change nothing. Result matches the golden Hamming count.
- **Reset mid-vector:**
  - Stimulus: assert `nrst` after 5 bits, then feed a full vector with `in_bit`=`proto_0` and `proto_1`=~`in_bit`.
  - Required: `dist_0`=0, `dist_1`=8, `class_out`=0. No residue from the aborted vector.
- **Back-to-back vectors:**
  - Required: vector-1 distances stay visible until the first bit of vector 2 is accepted, then restart from that bit's mismatches.
  - 100 random vectors with `DIM`=64 match a reference model.
